clock_monitor: RTL and testbench

Receive-side checker for the square-wave clocks the team generates. It samples an external toggling signal (mon_in) on the system clock and measures its high time, low time and period in clk cycles. It compares each half period against an expected value with a tolerance, and flags violations and stuck signals. It sits beside clock sources in benches and FPGA builds as a self-check on generated clocks.

---
 rtl/clock_monitor.sv | 197 +++++++++++++++++++
 tb/tb_clock_monitor.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_monitor.sv
// clock_monitor: measures high/low/period of an asynchronous square wave on clk.
// Define CLKMON_DUTY_EN to build the optional duty-cycle mismatch flag.
module clock_monitor #(
  parameter int CNT_W       = 16,
  parameter int EXP_HALF    = 20,
  parameter int TOL         = 1,
  parameter int TIMEOUT     = 80,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             mon_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic [CNT_W:0]   period_cnt,
  output logic             meas_valid,
  output logic             err_high,
  output logic             err_low,
  output logic             stuck,
  output logic             duty_err
);

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    MEAS_HIGH,
    MEAS_LOW
  } state_t;

  localparam logic [31:0] LO_LIM =
    (EXP_HALF > TOL) ? 32'(EXP_HALF - TOL) : 32'd0;
  localparam logic [31:0] HI_LIM  = 32'(EXP_HALF + TOL);
  localparam logic [31:0] TO_LIM  = 32'(TIMEOUT);
  localparam logic [CNT_W-1:0] RUN_MAX = '1;
  localparam logic [CNT_W-1:0] RUN_ONE = CNT_W'(1);

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s;
  logic                   s_prev_q, s_prev_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic [CNT_W-1:0]       run_q, run_d;
  logic [CNT_W-1:0]       high_q, high_d;
  logic [CNT_W-1:0]       low_q, low_d;
  logic [CNT_W:0]         period_q, period_d;
  logic                   valid_q, valid_d;
  logic                   eh_q, eh_d;
  logic                   el_q, el_d;
  logic                   stuck_q, stuck_d;
  logic                   timeout;

  function automatic logic out_of_tol(input logic [CNT_W-1:0] v);
    logic [31:0] w;
    w = 32'(v);
    return (w < LO_LIM) || (w > HI_LIM);
  endfunction

  assign s = sync_q[SYNC_STAGES-1];

  // Edge pulses are registered so the run count lines up with the capture.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], mon_in};
    s_prev_d = s;
    rise_d   = s & ~s_prev_q;
    fall_d   = ~s & s_prev_q;
    if (rise_q || fall_q) begin
      run_d = RUN_ONE;
    end else if (run_q == RUN_MAX) begin
      run_d = run_q;
    end else begin
      run_d = run_q + RUN_ONE;
    end
    timeout = 32'(run_d) >= TO_LIM;
  end

  always_comb begin
    state_d  = state_q;
    high_d   = high_q;
    low_d    = low_q;
    period_d = period_q;
    valid_d  = 1'b0;
    eh_d     = eh_q & ~clr;
    el_d     = el_q & ~clr;
    stuck_d  = 1'b0;
    if (!en) begin
      state_d = IDLE;
    end else begin
      stuck_d = (state_q != IDLE) && timeout;
      unique case (state_q)
        IDLE: begin
          state_d = ALIGN;
        end
        ALIGN: begin
          if (rise_q) begin
            state_d = MEAS_HIGH;
          end
        end
        MEAS_HIGH: begin
          if (fall_q) begin
            high_d  = run_q;
            state_d = MEAS_LOW;
            if (out_of_tol(run_q)) begin
              eh_d = 1'b1;
            end
          end else if (timeout) begin
            state_d = ALIGN;
          end
        end
        MEAS_LOW: begin
          if (rise_q) begin
            low_d    = run_q;
            period_d = {1'b0, high_q} + {1'b0, run_q};
            valid_d  = 1'b1;
            state_d  = MEAS_HIGH;
            if (out_of_tol(run_q)) begin
              el_d = 1'b1;
            end
          end else if (timeout) begin
            state_d = ALIGN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sync_q   <= '0;
      s_prev_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      run_q    <= '0;
      high_q   <= '0;
      low_q    <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      eh_q     <= 1'b0;
      el_q     <= 1'b0;
      stuck_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      s_prev_q <= s_prev_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      run_q    <= run_d;
      high_q   <= high_d;
      low_q    <= low_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      eh_q     <= eh_d;
      el_q     <= el_d;
      stuck_q  <= stuck_d;
    end
  end

`ifdef CLKMON_DUTY_EN
  localparam logic [31:0] DUTY_LIM = 32'(2 * TOL);

  logic             duty_q, duty_d;
  logic [CNT_W-1:0] duty_diff;

  // run_q holds the low time being captured on a period completion.
  always_comb begin
    duty_diff = (high_q >= run_q) ? high_q - run_q : run_q - high_q;
    duty_d    = duty_q & ~clr;
    if (valid_d && (32'(duty_diff) > DUTY_LIM)) begin
      duty_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      duty_q <= 1'b0;
    end else begin
      duty_q <= duty_d;
    end
  end

  assign duty_err = duty_q;
`else
  assign duty_err = 1'b0;
`endif

  assign high_cnt   = high_q;
  assign low_cnt    = low_q;
  assign period_cnt = period_q;
  assign meas_valid = valid_q;
  assign err_high   = eh_q;
  assign err_low    = el_q;
  assign stuck      = stuck_q;

endmodule

// File: tb/tb_clock_monitor.sv
// tb_clock_monitor: directed and random mon_in waveforms checked against a
// segment-level model (levels and hold lengths) of the clock monitor.
module tb_clock_monitor;

  localparam int EXP_HALF = 20;
  localparam int TOL      = 1;
  localparam int TIMEOUT  = 80;
  localparam int SYNC     = 2;
  localparam int SAT      = 65535;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        clr = 1'b0;
  logic        mon_in = 1'b0;
  logic        mon6 = 1'b0;
  logic [15:0] high_cnt, low_cnt;
  logic [16:0] period_cnt;
  logic        meas_valid, err_high, err_low, stuck, duty_err;
  logic [5:0]  high6, low6;
  logic [6:0]  period6;
  logic        valid6, eh6, el6, stuck6, duty6;

  always #5 clk = ~clk;

  clock_monitor dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mon_in(mon_in),
    .high_cnt(high_cnt), .low_cnt(low_cnt), .period_cnt(period_cnt),
    .meas_valid(meas_valid), .err_high(err_high), .err_low(err_low),
    .stuck(stuck), .duty_err(duty_err)
  );

  clock_monitor #(.CNT_W(6), .TIMEOUT(200)) dut6 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mon_in(mon6),
    .high_cnt(high6), .low_cnt(low6), .period_cnt(period6),
    .meas_valid(valid6), .err_high(eh6), .err_low(el6),
    .stuck(stuck6), .duty_err(duty6)
  );

  int checks = 0;
  int errors = 0;
  int n_valid = 0;

  typedef struct {
    int h;
    int l;
    int p;
  } meas_t;
  meas_t exp_q[$];

  bit m_en = 0, m_aligned = 0, m_have_high = 0;
  bit m_eh = 0, m_el = 0, m_duty = 0;
  int m_high = 0;
  int cur_lvl = 0;
  int cur_len = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit bad(input int v);
    return (v < EXP_HALF - TOL) || (v > EXP_HALF + TOL);
  endfunction

  // A completed level of length n: what the monitor should conclude from it.
  task automatic model_end(input int lvl, input int n);
    int v;
    v = (n > SAT) ? SAT : n;
    if (!m_en) return;
    if (n >= TIMEOUT) begin
      m_aligned   = (lvl == 0);
      m_have_high = 0;
      return;
    end
    if (lvl == 1) begin
      if (m_aligned) begin
        m_high      = v;
        m_have_high = 1;
        if (bad(v)) m_eh = 1;
      end
    end else begin
      if (m_have_high) begin
        exp_q.push_back('{m_high, v, m_high + v});
        if (bad(v)) m_el = 1;
`ifdef CLKMON_DUTY_EN
        if ((m_high > v ? m_high - v : v - m_high) > 2 * TOL) m_duty = 1;
`endif
        m_have_high = 0;
      end
      m_aligned = 1;
    end
  endtask

  task automatic start_level(input int lvl);
    if (lvl != cur_lvl) begin
      model_end(cur_lvl, cur_len);
      cur_lvl = lvl;
      cur_len = 0;
    end
    mon_in = lvl[0];
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
    cur_len += n;
  endtask

  task automatic seg(input int lvl, input int n);
    start_level(lvl);
    hold(n);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    hold(1);
    clr = 1'b0;
    m_eh = 0;
    m_el = 0;
    m_duty = 0;
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, "_err_high"}, 32'(err_high), 32'(m_eh));
    chk({tag, "_err_low"}, 32'(err_low), 32'(m_el));
    chk({tag, "_duty"}, 32'(duty_err), 32'(m_duty));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_high"}, 32'(high_cnt), 0);
    chk({tag, "_low"}, 32'(low_cnt), 0);
    chk({tag, "_period"}, 32'(period_cnt), 0);
    chk({tag, "_valid"}, 32'(meas_valid), 0);
    chk({tag, "_err_high"}, 32'(err_high), 0);
    chk({tag, "_err_low"}, 32'(err_low), 0);
    chk({tag, "_stuck"}, 32'(stuck), 0);
    chk({tag, "_duty"}, 32'(duty_err), 0);
  endtask

  always @(negedge clk) begin
    if (meas_valid === 1'b1) begin
      meas_t e;
      n_valid++;
      chk("valid_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_high", 32'(high_cnt), e.h);
        chk("sb_low", 32'(low_cnt), e.l);
        chk("sb_period", 32'(period_cnt), e.p);
      end
    end
  end

  initial begin
    int k_st;
    int nv0;

    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    en = 1'b1;
    m_en = 1;

    // nominal 20/20 clock
    hold(10);
    for (int i = 0; i < 10; i++) begin
      seg(1, 20);
      seg(0, 20);
    end
    seg(1, 10);
    chk("nominal_count", n_valid, 10);
    chk_flags("nominal");

    // long high, then clr with good periods after it
    hold(10);
    seg(0, 20);
    seg(1, 23);
    seg(0, 20);
    seg(1, 20);
    chk_flags("high23");
    pulse_clr();
    for (int i = 0; i < 2; i++) begin
      seg(0, 20);
      seg(1, 20);
    end
    chk_flags("after_clr");

    // random half periods around nominal
    for (int i = 0; i < 8; i++) begin
      seg(0, int'($urandom_range(24, 16)));
      seg(1, int'($urandom_range(24, 16)));
    end
    seg(0, 20);
    seg(1, 20);
    chk_flags("random");
    pulse_clr();

    // dropout: low for 100 cycles
    start_level(0);
    k_st = 0;
    for (int k = 1; k <= 100; k++) begin
      hold(1);
      if (stuck === 1'b1 && k_st == 0) k_st = k;
    end
    chk("stuck_rise", k_st, TIMEOUT + SYNC + 1);
    chk("stuck_level", 32'(stuck), 1);
    seg(1, 20);
    chk("stuck_clear", 32'(stuck), 0);
    nv0 = n_valid;
    seg(0, 20);
    seg(1, 20);
    chk("resume_count", n_valid - nv0, 1);
    chk_flags("resume");

    // disable mid-high, re-enable mid-low
    en = 1'b0;
    m_en = 0;
    m_aligned = 0;
    m_have_high = 0;
    hold(5);
    seg(0, 20);
    seg(1, 20);
    chk("dis_stuck", 32'(stuck), 0);
    chk("dis_hold_high", 32'(high_cnt), m_high);
    seg(0, 8);
    en = 1'b1;
    m_en = 1;
    hold(12);
    seg(1, 20);
    seg(0, 20);
    seg(1, 20);

    // 15/25 duty
    seg(0, 20);
    seg(1, 15);
    seg(0, 25);
    seg(1, 20);
    chk_flags("duty");
    pulse_clr();

    // reset while measuring low
    seg(0, 8);
    rst_n = 1'b0;
    hold(1);
    chk_zero("mid_reset");
    rst_n = 1'b1;
    m_aligned = 0;
    m_have_high = 0;
    m_high = 0;
    m_eh = 0;
    m_el = 0;
    m_duty = 0;
    nv0 = n_valid;
    hold(11);
    seg(1, 20);
    chk("post_reset_none", n_valid - nv0, 0);
    seg(0, 20);
    seg(1, 20);
    chk("post_reset_one", n_valid - nv0, 1);

    // 6-bit counters saturate on a 100-cycle high
    mon6 = 1'b1;
    repeat (100) @(negedge clk);
    mon6 = 1'b0;
    repeat (20) @(negedge clk);
    mon6 = 1'b1;
    repeat (8) @(negedge clk);
    chk("sat_high", 32'(high6), 63);
    chk("sat_low", 32'(low6), 20);
    chk("sat_period", 32'(period6), 83);
    chk("sat_err_high", 32'(eh6), 1);
    chk("sat_err_low", 32'(el6), 0);
    chk("sat_stuck", 32'(stuck6), 0);

    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
